// File: rtl/ram_test_gen.sv
// RAM march-style test generator: writes (seed + addr) to every word, reads it back and
// checks it through an RD_LAT-deep expected-data pipeline. Define RAM_TEST_ERRCNT_EN to add err_cnt.
module ram_test_gen #(
    parameter int DW     = 8,
    parameter int AW     = 5,
    parameter int RD_LAT = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          loop,
    output logic          ram_en,
    output logic          ram_we,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_wr_data,
    input  logic [DW-1:0] ram_rd_data,
    output logic          busy,
    output logic          done,
    output logic          pass_ok,
    output logic          err_flag,
    output logic [15:0]   err_cnt
);
    typedef enum logic [2:0] {S_IDLE, S_WRITE, S_READ, S_DRAIN, S_DONE} state_t;

    localparam logic [AW-1:0] LAST_ADDR  = '1;
    localparam logic [2:0]    DRAIN_LAST = 3'(RD_LAT - 1);

    state_t                       state_q, state_d;
    logic                         ram_en_q, ram_en_d;
    logic                         ram_we_q, ram_we_d;
    logic [AW-1:0]                ram_addr_q, ram_addr_d;
    logic [DW-1:0]                ram_wr_data_q, ram_wr_data_d;
    logic                         busy_q, busy_d;
    logic                         done_q, done_d;
    logic                         pass_ok_q, pass_ok_d;
    logic                         err_flag_q, err_flag_d;
    logic                         pass_err_q, pass_err_d;
    logic [DW-1:0]                seed_q, seed_d;
    logic [2:0]                   drain_q, drain_d;
    logic [RD_LAT-1:0]            chk_vld_q, chk_vld_d;
    logic [RD_LAT-1:0][DW-1:0]    chk_exp_q, chk_exp_d;
    logic                         accept_start;
    logic                         mismatch;

    assign accept_start = (state_q == S_IDLE) && start;
    // The oldest pipeline stage lines up with the data returned for that read address.
    assign mismatch     = chk_vld_q[RD_LAT-1] && (ram_rd_data != chk_exp_q[RD_LAT-1]);

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
        state_d       = state_q;
        ram_en_d      = ram_en_q;
        ram_we_d      = ram_we_q;
        ram_addr_d    = ram_addr_q;
        ram_wr_data_d = ram_wr_data_q;
        done_d        = 1'b0;
        pass_ok_d     = pass_ok_q;
        err_flag_d    = err_flag_q;
        pass_err_d    = pass_err_q;
        seed_d        = seed_q;
        drain_d       = drain_q;

        chk_vld_d[0] = (state_q == S_READ);
        chk_exp_d[0] = seed_q + DW'(ram_addr_q);
        for (int i = 1; i < RD_LAT; i++) begin
            chk_vld_d[i] = chk_vld_q[i-1];
            chk_exp_d[i] = chk_exp_q[i-1];
        end

        if (mismatch) begin
            err_flag_d = 1'b1;
            pass_err_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (accept_start) begin
                    state_d       = S_WRITE;
                    ram_en_d      = 1'b1;
                    ram_we_d      = 1'b1;
                    ram_addr_d    = '0;
                    ram_wr_data_d = '0;
                    seed_d        = '0;
                    err_flag_d    = 1'b0;
                    pass_err_d    = 1'b0;
                end
            end
            S_WRITE: begin
                if (ram_addr_q == LAST_ADDR) begin
                    state_d    = S_READ;
                    ram_we_d   = 1'b0;
                    ram_addr_d = '0;
                end else begin
                    ram_addr_d    = ram_addr_q + AW'(1);
                    ram_wr_data_d = seed_q + DW'(ram_addr_q + AW'(1));
                end
            end
            S_READ: begin
                if (ram_addr_q == LAST_ADDR) begin
                    state_d  = S_DRAIN;
                    ram_en_d = 1'b0;
                    drain_d  = DRAIN_LAST;
                end else begin
                    ram_addr_d = ram_addr_q + AW'(1);
                end
            end
            S_DRAIN: begin
                if (drain_q == 3'd0) begin
                    // The final read is compared on this same edge, hence pass_err_d.
                    state_d   = S_DONE;
                    done_d    = 1'b1;
                    pass_ok_d = ~pass_err_d;
                end else begin
                    drain_d = drain_q - 3'd1;
                end
            end
            S_DONE: begin
                if (loop) begin
                    state_d       = S_WRITE;
                    ram_en_d      = 1'b1;
                    ram_we_d      = 1'b1;
                    ram_addr_d    = '0;
                    seed_d        = seed_q + DW'(1);
                    ram_wr_data_d = seed_q + DW'(1);
                    pass_err_d    = 1'b0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) begin
            state_q       <= S_IDLE;
            ram_en_q      <= 1'b0;
            ram_we_q      <= 1'b0;
            ram_addr_q    <= '0;
            ram_wr_data_q <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            pass_ok_q     <= 1'b0;
            err_flag_q    <= 1'b0;
            pass_err_q    <= 1'b0;
            seed_q        <= '0;
            drain_q       <= '0;
            // NOTE: the checker pipeline is reset, unlike a RAM array, so in-flight reads die with reset.
            chk_vld_q     <= '0;
            chk_exp_q     <= '0;
        end else begin
            state_q       <= state_d;
            ram_en_q      <= ram_en_d;
            ram_we_q      <= ram_we_d;
            ram_addr_q    <= ram_addr_d;
            ram_wr_data_q <= ram_wr_data_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            pass_ok_q     <= pass_ok_d;
            err_flag_q    <= err_flag_d;
            pass_err_q    <= pass_err_d;
            seed_q        <= seed_d;
            drain_q       <= drain_d;
            chk_vld_q     <= chk_vld_d;
            chk_exp_q     <= chk_exp_d;
        end
    end

`ifdef RAM_TEST_ERRCNT_EN
    logic [15:0] err_cnt_q, err_cnt_d;

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (accept_start) begin
            err_cnt_d = '0;
        end else if (mismatch && (err_cnt_q != 16'hFFFF)) begin
            err_cnt_d = err_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_cnt = err_cnt_q;
`else
    assign err_cnt = '0;
`endif

    assign ram_en      = ram_en_q;
    assign ram_we      = ram_we_q;
    assign ram_addr    = ram_addr_q;
    assign ram_wr_data = ram_wr_data_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign pass_ok     = pass_ok_q;
    assign err_flag    = err_flag_q;
endmodule

// File: tb/tb_ram_test_gen.sv
// Bench for ram_test_gen: RAM models, an access scoreboard, and pass timing/result checks
// for RD_LAT = 1 (main instance) and RD_LAT = 3 (second instance).
module tb_ram_test_gen;
    localparam int DW = 8;
    localparam int AW = 5;
`ifdef RAM_TEST_ERRCNT_EN
    localparam int CNT_EN = 1;
`else
    localparam int CNT_EN = 0;
`endif

    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } acc_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          start = 1'b0;
    logic          loop = 1'b0;
    logic          ram_en, ram_we, busy, done, pass_ok, err_flag;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wr_data, ram_rd_data;
    logic [15:0]   err_cnt;

    logic          start3 = 1'b0;
    logic          loop3 = 1'b0;
    logic          ram_en3, ram_we3, busy3, done3, pass_ok3, err_flag3;
    logic [AW-1:0] ram_addr3;
    logic [DW-1:0] ram_wr_data3, ram_rd_data3;
    logic [15:0]   err_cnt3;

    int n_checks = 0;
    int n_errors = 0;

    acc_t          sb_q[$];
    logic [DW-1:0] mem  [2**AW];
    logic [DW-1:0] mem3 [2**AW];
    logic [DW-1:0] rd1;
    logic [DW-1:0] rd3 [4];
    bit            flip_en = 1'b0;
    int            model_lat = 3;

    always #5 clk = ~clk;

    ram_test_gen #(.DW(DW), .AW(AW), .RD_LAT(1)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .loop(loop),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_wr_data(ram_wr_data), .ram_rd_data(ram_rd_data),
        .busy(busy), .done(done), .pass_ok(pass_ok),
        .err_flag(err_flag), .err_cnt(err_cnt)
    );

    ram_test_gen #(.DW(DW), .AW(AW), .RD_LAT(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .loop(loop3),
        .ram_en(ram_en3), .ram_we(ram_we3), .ram_addr(ram_addr3),
        .ram_wr_data(ram_wr_data3), .ram_rd_data(ram_rd_data3),
        .busy(busy3), .done(done3), .pass_ok(pass_ok3),
        .err_flag(err_flag3), .err_cnt(err_cnt3)
    );

    // Latency-1 RAM; optionally flips bit 0 of address 7 on readback.
    always @(posedge clk) begin
        if (ram_en && ram_we) mem[ram_addr] <= ram_wr_data;
        rd1 <= (flip_en && ram_addr == 5'd7) ? (mem[ram_addr] ^ 8'h01) : mem[ram_addr];
    end
    assign ram_rd_data = rd1;

    // RAM with selectable latency 1..4 for the RD_LAT = 3 instance.
    always @(posedge clk) begin
        if (ram_en3 && ram_we3) mem3[ram_addr3] <= ram_wr_data3;
        rd3[0] <= mem3[ram_addr3];
        for (int i = 1; i < 4; i++) rd3[i] <= rd3[i-1];
    end
    assign ram_rd_data3 = rd3[model_lat-1];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Scoreboard: every enabled RAM access of the main instance must match the next queued one.
    always @(negedge clk) begin : monitor
        acc_t obs;
        acc_t e;
        logic have_exp;
        if (rst_n && ram_en) begin
            obs.we   = ram_we;
            obs.addr = ram_addr;
            obs.data = ram_we ? ram_wr_data : '0;
            have_exp = (sb_q.size() != 0);
            e = have_exp ? sb_q.pop_front() : '0;
            check("acc", 32'({have_exp, obs}), 32'({1'b1, e}));
        end
    end

    task automatic push_pass(input logic [DW-1:0] seed);
        acc_t a;
        for (int i = 0; i < 2**AW; i++) begin
            a.we = 1'b1; a.addr = AW'(i); a.data = seed + DW'(i);
            sb_q.push_back(a);
        end
        for (int i = 0; i < 2**AW; i++) begin
            a.we = 1'b0; a.addr = AW'(i); a.data = '0;
            sb_q.push_back(a);
        end
    endtask

    task automatic kick(input int passes);
        for (int p = 0; p < passes; p++) push_pass(DW'(p));
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Counts negedges until done; optional start pulse and loop drop at given cycle numbers.
    task automatic wait_done(input int pulse_at, input int drop_at, output int n);
        n = 0;
        for (int c = 1; c <= 300; c++) begin
            @(negedge clk);
            if (c == pulse_at) start = 1'b1;
            else if (c == pulse_at + 1) start = 1'b0;
            if (c == drop_at) loop = 1'b0;
            if (done) begin
                n = c;
                break;
            end
        end
        start = 1'b0;
    endtask

    task automatic run3(output int n, output int drain);
        @(negedge clk);
        start3 = 1'b1;
        @(posedge clk);
        #1 start3 = 1'b0;
        n = 0;
        drain = 0;
        for (int c = 1; c <= 300; c++) begin
            @(negedge clk);
            if (busy3 && !ram_en3 && !done3) drain++;
            if (done3) begin
                n = c;
                break;
            end
        end
    endtask

    initial begin
        int n;
        int dr;
        bit found;

        #2 rst_n = 1'b0;
        #1;
        check("rst_busy", 32'(busy), 0);
        check("rst_en_we", 32'({ram_en, ram_we}), 0);
        check("rst_addr_data", 32'({ram_addr, ram_wr_data}), 0);
        check("rst_flags", 32'({done, pass_ok, err_flag}), 0);
        check("rst_cnt", 32'(err_cnt), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Clean pass with ideal RAM.
        kick(1);
        wait_done(0, 0, n);
        check("p1_len", 32'(n), 66);
        check("p1_ok", 32'(pass_ok), 1);
        check("p1_flag", 32'(err_flag), 0);
        check("p1_cnt", 32'(err_cnt), 0);
        @(negedge clk);
        check("p1_idle", 32'({busy, ram_en, ram_we}), 0);
        check("p1_hold", 32'({ram_addr, ram_wr_data}), 32'({5'd31, 8'd31}));
        check("p1_sb", 32'(sb_q.size()), 0);

        // Single corrupted word.
        flip_en = 1'b1;
        kick(1);
        wait_done(0, 0, n);
        check("p2_len", 32'(n), 66);
        check("p2_ok", 32'(pass_ok), 0);
        check("p2_flag", 32'(err_flag), 1);
        check("p2_cnt", 32'(err_cnt), 32'(CNT_EN));
        flip_en = 1'b0;
        @(negedge clk);

        // Three looped passes; loop drops midway through the third.
        loop = 1'b1;
        kick(3);
        wait_done(0, 0, n);
        check("l1_len", 32'(n), 66);
        check("l1_ok", 32'(pass_ok), 1);
        wait_done(0, 0, n);
        check("l2_len", 32'(n), 66);
        check("l2_ok", 32'(pass_ok), 1);
        wait_done(0, 10, n);
        check("l3_len", 32'(n), 66);
        check("l3_ok", 32'({pass_ok, err_flag}), 32'(2'b10));
        @(negedge clk);
        check("l3_idle", 32'(busy), 0);
        check("l3_sb", 32'(sb_q.size()), 0);

        // start pulsed during WRITE must be ignored.
        kick(1);
        wait_done(5, 0, n);
        check("sw_len", 32'(n), 66);
        check("sw_ok", 32'(pass_ok), 1);
        @(negedge clk);
        check("sw_sb", 32'(sb_q.size()), 0);

        // Reset while reading address 10.
        kick(1);
        found = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (ram_en && !ram_we && ram_addr == 5'd10) begin
                found = 1'b1;
                break;
            end
        end
        check("mr_found", 32'(found), 1);
        rst_n = 1'b0;
        #1;
        check("mr_busy", 32'({busy, done}), 0);
        check("mr_ram", 32'({ram_en, ram_we, ram_addr, ram_wr_data}), 0);
        check("mr_flags", 32'({pass_ok, err_flag}), 0);
        check("mr_cnt", 32'(err_cnt), 0);
        sb_q.delete();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("mr_after", 32'({busy, err_flag}), 0);
        check("mr_after_cnt", 32'(err_cnt), 0);
        kick(1);
        wait_done(0, 0, n);
        check("mr_len", 32'(n), 66);
        check("mr_ok", 32'({pass_ok, err_flag}), 32'(2'b10));
        @(negedge clk);

        // RD_LAT = 3 instance: matching model, then a model one cycle too fast.
        model_lat = 3;
        run3(n, dr);
        check("r3_len", 32'(n), 68);
        check("r3_drain", 32'(dr), 3);
        check("r3_ok", 32'({pass_ok3, err_flag3}), 32'(2'b10));
        check("r3_cnt", 32'(err_cnt3), 0);
        @(negedge clk);
        model_lat = 2;
        run3(n, dr);
        check("r2_len", 32'(n), 68);
        check("r2_ok", 32'({pass_ok3, err_flag3}), 32'(2'b01));
        check("r2_cnt_nz", 32'(err_cnt3 != 16'd0), 32'(CNT_EN));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
